arb_req_buffer: RTL and testbench
=================================

# arb_req_buffer

Two-client request front-end for the two-way grant arbiter. Each client pushes data words into its own small FIFO; a non-empty FIFO drives that client's request line (R0/R1) into the arbiter, and each grant (G0/G1) returned by the arbiter pops one word from the matching FIFO. The popped word appears on a single shared output port, tagged with its source client. The block sits directly upstream of the arbiter, generating its requests and consuming its grants.

## Interface
Parameters:
- DATA_W, 8: payload width of each client word.
- DEPTH, 4: entries per client FIFO; power of two, at least 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- in0_valid  in  1  client 0 offers a word.
- in0_data  in  DATA_W  client 0 word.
- in0_ready  out  1  FIFO 0 can accept a word (= !full0).
- in1_valid, in1_data, in1_ready: same as client 0, for client 1.
- R0  out  1  request to arbiter (= FIFO 0 non-empty).
- R1  out  1  request to arbiter (= FIFO 1 non-empty).
- G0  in  1  grant from arbiter for client 0.
- G1  in  1  grant from arbiter for client 1.
- out_valid  out  1  out_data/out_src valid this cycle; single-cycle pulse per pop.
- out_data  out  DATA_W  popped word.
- out_src  out  1  source of the popped word: 0 = client 0, 1 = client 1.
- ovf0, ovf1  out  1  sticky drop flags; present only with ARB_REQ_BUF_OVF_EN.

## Operation
- Push: on a clock edge with inX_valid && inX_ready, the word is written at the tail of FIFO X. Words with inX_valid && !inX_ready are not written.
- Request: RX = (countX != 0). It is derived only from registered count, so it is glitch-free.
- Pop: on a clock edge with GX = 1 and countX != 0, the head is removed. out_data <= head, out_src <= X, out_valid <= 1.
- A grant to an empty FIFO is ignored: no pop, and out_valid <= 0.
- G0 and G1 both high: G0 wins, FIFO 1 is untouched. The arbiter never drives both; this rule only fixes the defined behaviour.
- Push and pop in the same cycle on one FIFO are both performed and the count is unchanged. A pop on a full FIFO frees its slot on the next cycle only, because in_ready is computed from the pre-pop count.
- Push on an empty FIFO with a grant in the same cycle: the push is accepted and the grant is ignored.
- Count is $clog2(DEPTH)+1 bits. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset asserted mid-operation: both FIFOs are emptied immediately and in-flight words are lost. out_valid clears asynchronously.

## Timing
- Reset values: R0 = R1 = 0, out_valid = 0, out_data = 0, out_src = 0, in0_ready = in1_ready = 1, ovf0 = ovf1 = 0. Pointers and counts are 0.
- Request latency: a word pushed at edge N raises RX after edge N. Arbiter grant arrives after edge N+1, and out_valid is high after edge N+2.
- One output word per grant cycle; sustained throughput is one word per clock.
- A held grant drains one word per cycle. RX drops in the cycle after the last pop.
- No back-pressure on the output side; the consumer must accept every out_valid pulse.

## Configuration
- ARB_REQ_BUF_OVF_EN defined: ports ovf0/ovf1 exist. ovfX is set on any edge where inX_valid = 1 and FIFO X is full. It stays set until reset.
- Not defined: ports and logic are absent. Refused offers are silent, and behaviour is otherwise identical.

## Structure
- Shared package arb_req_pkg holds:
  - the default DATA_W and DEPTH constants;
  - the source encoding SRC_C0 = 1'b0, SRC_C1 = 1'b1;
  - a typedef for the count width derived from DEPTH.
- Sub-module req_fifo, instantiated twice: a synchronous FIFO with push/pop, full, empty and count. The top level holds the request mapping, grant priority, output register and overflow flags.

## Test plan
- Reset, then push 0xA5 on client 0 with G0 looped from R0 one cycle later → R0 high after edge 1, out_valid at edge 3 with out_data = 0xA5, out_src = 0, then R0 = 0.
- Fill FIFO 1 with 0x10..0x13 (DEPTH = 4) → in1_ready = 0. Hold G1 for 4 cycles → outputs 0x10, 0x11, 0x12, 0x13 in order, src = 1, then in1_ready = 1.
- Both FIFOs loaded with 2 words each, driven by the real arbiter → out_src alternates 0, 1, 0, 1 and all 4 words are delivered.
- G0 pulsed with FIFO 0 empty, and G0 = G1 = 1 with both FIFOs non-empty → no output in the first case; in the second, a client 0 word is output and count1 is unchanged.
- With ARB_REQ_BUF_OVF_EN: offer a 5th word to full FIFO 0 → word is not stored and ovf0 = 1 until reset. Assert reset mid-drain → out_valid, R0, R1 = 0 immediately and the FIFOs are empty.

Source files
------------

// File: rtl/arb_req_pkg.sv
// -----------------------------------------------------------------------------
// arb_req_pkg
// Shared constants for the two-client arbiter request front-end.
//   DEF_DATA_W / DEF_DEPTH : default payload width and per-client FIFO depth
//   SRC_C0 / SRC_C1        : encoding of out_src
//   cnt_t                  : count type for the default depth
//   cnt_width()            : count width for an arbitrary depth
// -----------------------------------------------------------------------------
package arb_req_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 4;

   localparam logic SRC_C0 = 1'b0;
   localparam logic SRC_C1 = 1'b1;

   // One extra bit so a full FIFO (count == DEPTH) is representable.
   localparam int DEF_CNT_W = $clog2(DEF_DEPTH) + 1;
   typedef logic [DEF_CNT_W-1:0] cnt_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/arb_req_buffer_if.sv
// -----------------------------------------------------------------------------
// arb_req_buffer_if
// Bundles the client push handshakes, the arbiter request/grant pair and the
// shared output port of arb_req_buffer.
//   in0_*/in1_*   : client push handshakes (valid, data, ready)
//   R0/R1, G0/G1  : request to / grant from the two-way arbiter
//   out_*         : popped word, source tag and single-cycle valid
//   ovf0/ovf1     : sticky drop flags, only with ARB_REQ_BUF_OVF_EN
// Modports: slave = the buffer, master = clients plus arbiter side.
// -----------------------------------------------------------------------------
interface arb_req_buffer_if #(
   parameter int DATA_W = 8
);
   logic              in0_valid;
   logic [DATA_W-1:0] in0_data;
   logic              in0_ready;
   logic              in1_valid;
   logic [DATA_W-1:0] in1_data;
   logic              in1_ready;
   logic              R0;
   logic              R1;
   logic              G0;
   logic              G1;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_src;
`ifdef ARB_REQ_BUF_OVF_EN
   logic              ovf0;
   logic              ovf1;

   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, G0, G1,
      output in0_ready, in1_ready, R0, R1, out_valid, out_data, out_src,
             ovf0, ovf1
   );

   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, G0, G1,
      input  in0_ready, in1_ready, R0, R1, out_valid, out_data, out_src,
             ovf0, ovf1
   );
`else
   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, G0, G1,
      output in0_ready, in1_ready, R0, R1, out_valid, out_data, out_src
   );

   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, G0, G1,
      input  in0_ready, in1_ready, R0, R1, out_valid, out_data, out_src
   );
`endif
endinterface

// File: rtl/req_fifo.sv
// -----------------------------------------------------------------------------
// req_fifo
// Synchronous FIFO for one arbiter client.
//   clock, reset       : rising-edge clock, async active-low reset
//   push, push_data    : write request; ignored while full
//   pop                : remove head; ignored while empty
//   head_data          : current head word (valid while !empty)
//   full, empty, count : occupancy status, all from registered count
// Push and pop in one cycle are both performed; full is evaluated on the
// pre-pop count, so a popped slot is reusable only from the next cycle.
// -----------------------------------------------------------------------------
module req_fifo
   import arb_req_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = cnt_width(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign head_data = mem[rd_ptr];

   // Storage needs no reset: contents are only observed behind count.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are PTR_W bits wide and wrap DEPTH-1 -> 0 on their own.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/arb_req_buffer.sv
// -----------------------------------------------------------------------------
// arb_req_buffer
// Two-client request front-end for the two-way grant arbiter. Each client
// fills its own req_fifo; a non-empty FIFO raises its request, and each grant
// pops one word onto the shared registered output, tagged with its source.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : arb_req_buffer_if.slave (client handshakes, R0/R1, G0/G1,
//           out_valid/out_data/out_src, and ovf0/ovf1 when enabled)
// Optional feature: define ARB_REQ_BUF_OVF_EN to add the sticky ovf0/ovf1
// drop flags, set whenever a client offers a word to its full FIFO.
// -----------------------------------------------------------------------------
module arb_req_buffer
   import arb_req_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int CNT_W  = cnt_width(DEPTH)
) (
   input  logic               clock,
   input  logic               reset,
   arb_req_buffer_if.slave    bus
);

   logic [DATA_W-1:0] head0;
   logic [DATA_W-1:0] head1;
   logic              full0;
   logic              full1;
   logic              empty0;
   logic              empty1;
   logic [CNT_W-1:0]  count0;
   logic [CNT_W-1:0]  count1;
   logic              pop0;
   logic              pop1;

   // G0 has priority; with both grants high FIFO 1 is left alone even if
   // FIFO 0 happens to be empty.
   assign pop0 = bus.G0 && !empty0;
   assign pop1 = bus.G1 && !bus.G0 && !empty1;

   req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo0 (
      .clock     (clock),
      .reset     (reset),
      .push      (bus.in0_valid),
      .push_data (bus.in0_data),
      .pop       (pop0),
      .head_data (head0),
      .full      (full0),
      .empty     (empty0),
      .count     (count0)
   );

   req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo1 (
      .clock     (clock),
      .reset     (reset),
      .push      (bus.in1_valid),
      .push_data (bus.in1_data),
      .pop       (pop1),
      .head_data (head1),
      .full      (full1),
      .empty     (empty1),
      .count     (count1)
   );

   assign bus.in0_ready = !full0;
   assign bus.in1_ready = !full1;

   // Requests come straight from registered counts, so they cannot glitch.
   assign bus.R0 = (count0 != '0);
   assign bus.R1 = (count1 != '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_src   <= SRC_C0;
      end else if (pop0) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= head0;
         bus.out_src   <= SRC_C0;
      end else if (pop1) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= head1;
         bus.out_src   <= SRC_C1;
      end else begin
         bus.out_valid <= 1'b0;
      end
   end

`ifdef ARB_REQ_BUF_OVF_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.ovf0 <= 1'b0;
         bus.ovf1 <= 1'b0;
      end else begin
         if (bus.in0_valid && full0) begin
            bus.ovf0 <= 1'b1;
         end
         if (bus.in1_valid && full1) begin
            bus.ovf1 <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_arb_req_buffer.sv
// -----------------------------------------------------------------------------
// tb_arb_req_buffer
// Directed bench for arb_req_buffer (DATA_W = 8, DEPTH = 4). Inputs change
// and outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_arb_req_buffer;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;

   arb_req_buffer_if #(.DATA_W(8)) bus ();

   arb_req_buffer #(
      .DATA_W (8),
      .DEPTH  (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [7:0] exp_data [4];
   logic       exp_src  [4];
   int         k;
   logic       last_g;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b0;
      bus.in0_valid = 1'b0;
      bus.in0_data  = '0;
      bus.in1_valid = 1'b0;
      bus.in1_data  = '0;
      bus.G0 = 1'b0;
      bus.G1 = 1'b0;
      #12;

      // Reset values
      check("rst_R0", 32'(bus.R0), 32'd0);
      check("rst_R1", 32'(bus.R1), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'h00);
      check("rst_out_src", 32'(bus.out_src), 32'd0);
      check("rst_in0_ready", 32'(bus.in0_ready), 32'd1);
      check("rst_in1_ready", 32'(bus.in1_ready), 32'd1);
`ifdef ARB_REQ_BUF_OVF_EN
      check("rst_ovf0", 32'(bus.ovf0), 32'd0);
      check("rst_ovf1", 32'(bus.ovf1), 32'd0);
`endif
      reset = 1'b1;
      step();

      // Single word, registered-grant latency: push edge1, grant after edge2,
      // output after edge3.
      bus.in0_valid = 1'b1;
      bus.in0_data  = 8'hA5;
      step();
      bus.in0_valid = 1'b0;
      check("lat_R0_after_push", 32'(bus.R0), 32'd1);
      check("lat_no_out_e1", 32'(bus.out_valid), 32'd0);
      step();
      check("lat_no_out_e2", 32'(bus.out_valid), 32'd0);
      bus.G0 = 1'b1;
      step();
      check("lat_out_valid_e3", 32'(bus.out_valid), 32'd1);
      check("lat_out_data", 32'(bus.out_data), 32'hA5);
      check("lat_out_src", 32'(bus.out_src), 32'd0);
      check("lat_R0_drop", 32'(bus.R0), 32'd0);
      bus.G0 = 1'b0;
      step();
      check("lat_pulse_end", 32'(bus.out_valid), 32'd0);

      // Fill FIFO 1 then drain with a held grant
      for (int i = 0; i < 4; i++) begin
         bus.in1_valid = 1'b1;
         bus.in1_data  = 8'h10 + 8'(i);
         step();
      end
      bus.in1_valid = 1'b0;
      check("fill1_in1_ready", 32'(bus.in1_ready), 32'd0);
      check("fill1_R1", 32'(bus.R1), 32'd1);
      bus.G1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("drain1_valid", 32'(bus.out_valid), 32'd1);
         check("drain1_data", 32'(bus.out_data), 32'h10 + 32'(i));
         check("drain1_src", 32'(bus.out_src), 32'd1);
      end
      check("drain1_R1_drop", 32'(bus.R1), 32'd0);
      check("drain1_in1_ready", 32'(bus.in1_ready), 32'd1);
      bus.G1 = 1'b0;
      step();
      check("drain1_idle", 32'(bus.out_valid), 32'd0);

      // Two words per client, round-robin arbiter in the bench
      for (int i = 0; i < 2; i++) begin
         bus.in0_valid = 1'b1;
         bus.in0_data  = 8'h30 + 8'(i);
         bus.in1_valid = 1'b1;
         bus.in1_data  = 8'h40 + 8'(i);
         step();
      end
      bus.in0_valid = 1'b0;
      bus.in1_valid = 1'b0;
      exp_data[0] = 8'h30; exp_src[0] = 1'b0;
      exp_data[1] = 8'h40; exp_src[1] = 1'b1;
      exp_data[2] = 8'h31; exp_src[2] = 1'b0;
      exp_data[3] = 8'h41; exp_src[3] = 1'b1;
      k      = 0;
      last_g = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (bus.out_valid) begin
            if (k < 4) begin
               check("rr_data", 32'(bus.out_data), 32'(exp_data[k]));
               check("rr_src", 32'(bus.out_src), 32'(exp_src[k]));
            end
            k++;
         end
         bus.G0 = 1'b0;
         bus.G1 = 1'b0;
         if (bus.R0 && (!bus.R1 || last_g)) begin
            bus.G0 = 1'b1;
            last_g = 1'b0;
         end else if (bus.R1) begin
            bus.G1 = 1'b1;
            last_g = 1'b1;
         end
         step();
      end
      bus.G0 = 1'b0;
      bus.G1 = 1'b0;
      check("rr_word_count", 32'(k), 32'd4);

      // Grant to an empty FIFO is ignored
      bus.G0 = 1'b1;
      step();
      check("empty_grant_no_out", 32'(bus.out_valid), 32'd0);
      check("empty_grant_R0", 32'(bus.R0), 32'd0);
      bus.G0 = 1'b0;

      // Both grants high: G0 wins, FIFO 1 untouched
      bus.in0_valid = 1'b1;
      bus.in0_data  = 8'h50;
      bus.in1_valid = 1'b1;
      bus.in1_data  = 8'h60;
      step();
      bus.in0_valid = 1'b0;
      bus.in1_data  = 8'h61;
      step();
      bus.in1_valid = 1'b0;
      bus.G0 = 1'b1;
      bus.G1 = 1'b1;
      step();
      check("both_g_valid", 32'(bus.out_valid), 32'd1);
      check("both_g_data", 32'(bus.out_data), 32'h50);
      check("both_g_src", 32'(bus.out_src), 32'd0);
      check("both_g_R0", 32'(bus.R0), 32'd0);
      check("both_g_R1", 32'(bus.R1), 32'd1);
      step();
      check("both_g_g0_empty", 32'(bus.out_valid), 32'd0);
      check("both_g_R1_kept", 32'(bus.R1), 32'd1);
      bus.G0 = 1'b0;
      step();
      check("both_g_c1_first", 32'(bus.out_data), 32'h60);
      check("both_g_c1_first_v", 32'(bus.out_valid), 32'd1);
      step();
      check("both_g_c1_second", 32'(bus.out_data), 32'h61);
      check("both_g_R1_drop", 32'(bus.R1), 32'd0);
      bus.G1 = 1'b0;

      // Full FIFO 0: a 5th offer is refused; push+pop on full refuses push
      for (int i = 0; i < 4; i++) begin
         bus.in0_valid = 1'b1;
         bus.in0_data  = 8'h20 + 8'(i);
         step();
      end
      bus.in0_data = 8'h99;
      step();
      check("full0_in0_ready", 32'(bus.in0_ready), 32'd0);
`ifdef ARB_REQ_BUF_OVF_EN
      check("full0_ovf0_set", 32'(bus.ovf0), 32'd1);
      check("full0_ovf1_clear", 32'(bus.ovf1), 32'd0);
`endif
      bus.in0_data = 8'h77;
      bus.G0 = 1'b1;
      step();
      bus.in0_valid = 1'b0;
      check("fullpop_data", 32'(bus.out_data), 32'h20);
      check("fullpop_in0_ready", 32'(bus.in0_ready), 32'd1);
      for (int i = 1; i < 4; i++) begin
         step();
         check("full0_drain_data", 32'(bus.out_data), 32'h20 + 32'(i));
         check("full0_drain_valid", 32'(bus.out_valid), 32'd1);
      end
      check("full0_no_extra", 32'(bus.R0), 32'd0);
      bus.G0 = 1'b0;
`ifdef ARB_REQ_BUF_OVF_EN
      check("ovf0_sticky", 32'(bus.ovf0), 32'd1);
`endif

      // Reset mid-drain
      bus.in0_valid = 1'b1;
      bus.in0_data  = 8'h81;
      bus.in1_valid = 1'b1;
      bus.in1_data  = 8'h82;
      step();
      bus.in0_valid = 1'b0;
      bus.in1_valid = 1'b0;
      bus.G0 = 1'b1;
      step();
      check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
      check("mid_pre_R1", 32'(bus.R1), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_R0", 32'(bus.R0), 32'd0);
      check("mid_rst_R1", 32'(bus.R1), 32'd0);
      check("mid_rst_in0_ready", 32'(bus.in0_ready), 32'd1);
`ifdef ARB_REQ_BUF_OVF_EN
      check("mid_rst_ovf0", 32'(bus.ovf0), 32'd0);
`endif
      #1;
      reset = 1'b1;
      bus.G0 = 1'b0;
      bus.G1 = 1'b1;
      step();
      check("post_rst_fifo1_empty", 32'(bus.out_valid), 32'd0);
      check("post_rst_R1", 32'(bus.R1), 32'd0);
      bus.G1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
